mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester round-robin arbiter and sequencer in front of the single-port `memory` block (synchronous write, registered read). It accepts read/write commands from two clients over a req/gnt handshake and drives `memory`'s `write_enb`/`read_enb`/`address`/`data_in`. It returns read data with a one-cycle `rvalid` strobe. It sits between the client logic and `memory` in the memory subsystem top, and does not instantiate `memory` itself.

## Interface
- `width`, 4, address width; matches `memory` `width`.
- `data_width`, 8, data width; matches `memory` `data_width`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req0`, `req1`  in  1 each  request; held with command until `gnt`.
- `we0`, `we1`  in  1 each  1 = write, 0 = read.
- `addr0`, `addr1`  in  `width` each  target address.
- `wdata0`, `wdata1`  in  `data_width` each  write data.
- `gnt0`, `gnt1`  out  1 each  one-cycle accept pulse.
- `rvalid0`, `rvalid1`  out  1 each  one-cycle read-data-valid pulse.
- `rdata`  out  `data_width`  read data; shared, qualified by `rvalid*`.
- `mem_write_enb`  out  1  to `memory.write_enb`.
- `mem_read_enb`  out  1  to `memory.read_enb`.
- `mem_address`  out  `width`  to `memory.address`.
- `mem_data_in`  out  `data_width`  to `memory.data_in`.
- `mem_data_out`  in  `data_width`  from `memory.data_out`.

## Operation
- FSM states:
  - IDLE: requests are sampled only here.
  - ACCESS: the memory command is driven for exactly one cycle.
  - RESP: reads only.
- IDLE → ACCESS when `req0|req1` at a clock edge. The winner's command is registered, the winner's `gnt` goes high for the ACCESS cycle, and `last_gnt` is updated to the winner.
- Arbitration:
  - Single request: that requester wins.
  - Both requesting: the requester not equal to `last_gnt` wins.
  - `last_gnt` resets to 1, so requester 0 wins the first tie.
- ACCESS behaviour:
  - `mem_write_enb` = registered `we`; `mem_read_enb` = registered `!we`.
  - `mem_address` and `mem_data_in` = registered `addr` and `wdata`.
  - Exactly one enable is high.
- ACCESS → IDLE for writes; ACCESS → RESP for reads.
- RESP: `rvalid` of the read's owner is high and `rdata` = `mem_data_out`; then → IDLE.
- `req*` is ignored in ACCESS and RESP. A requester must change or drop its command at the edge ending its `gnt` cycle. A `req` still high in the following IDLE cycle is a new request.
- Reset values (all outputs registered except `rdata`):
  - state = IDLE, `last_gnt` = 1.
  - `gnt*`, `rvalid*`, `mem_write_enb`, `mem_read_enb` = 0.
  - `mem_address`, `mem_data_in` = 0.
  - `rdata` = `mem_data_out` passthrough, don't-care without `rvalid`.
- Reset mid-operation: the FSM returns to IDLE at that edge and the pending transaction is discarded. No `gnt` or `rvalid` is produced for it, and the `memory` contents written before reset are not this block's concern.
- Memory enables are never both high. They are never high outside ACCESS.

## Timing
- `req` sampled at edge E (IDLE):
  - `gnt` and memory enables are high in cycle E+1.
  - `memory` writes or reads at edge E+1.
- Write throughput: IDLE again in cycle E+2, so one write per 2 cycles.
- Read latency: `rvalid` and valid `rdata` in cycle E+2, which is 2 cycles from the sample edge. IDLE again in cycle E+3, so one read per 3 cycles.
- Back-to-back contention: with both `req` held continuously, grants strictly alternate 0,1,0,1…
- Simultaneous events:
  - A new `req` arriving during ACCESS or RESP waits for IDLE; no loss, no early grant.
  - `reset` asserted in the same cycle as IDLE `req`: reset wins and no grant is issued.

## Structure
- Shared package `mem_arb_pkg` holds:
  - state enum (IDLE, ACCESS, RESP);
  - `NUM_REQ` = 2;
  - requester-index type.
- One sub-module, `mem_arb_rr`: a combinational 2-way round-robin pick (inputs `req[1:0]`, `last_gnt`; outputs `winner`, `valid`).
- FSM, command registers and output decode stay in `mem_arbiter`.
- The subsystem top wires `mem_arbiter` to `memory`, with `memory.reset` tied to `reset`.

## Test plan
- Reset: hold `reset` 2 cycles with `req0`=1 → no `gnt`/`rvalid`/enables high; `last_gnt`=1.
- Write then read, single client: `req0` `we0`=1 `addr0`=3 `wdata0`=A5; then `req0` `we0`=0 `addr0`=3 → `mem_write_enb` one cycle with `mem_address`=3 `mem_data_in`=A5; later `rvalid0`=1, `rdata`=A5 exactly 2 cycles after the read sample edge.
- Contention: `req0` and `req1` held for 4 writes each (`addr0`=1,`wdata0`=11; `addr1`=2,`wdata1`=22) → grant order 0,1,0,1,… with no two consecutive grants to the same requester; reads of addresses 1 and 2 return 11 and 22.
- Interleaved reads: `req0` reads addr 1, `req1` reads addr 2 simultaneously → `rvalid0` with 11, then `rvalid1` with 22; never both `rvalid`s high together.
- Late arrival: `req1` rises during `req0`'s ACCESS cycle → `gnt1` only after the FSM returns to IDLE; `req0`'s transaction is unaffected.
- Reset mid-read: assert `reset` in the ACCESS cycle of a read of addr 5 → no `rvalid`; FSM in IDLE the next cycle; a subsequent `req1` read is granted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory arbiter
package mem_arb_pkg;
  localparam int NUM_REQ = 2;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: client req/gnt bus plus memory-side command bus of mem_arbiter
// slave: arbiter view (takes client commands and mem_data_out, drives grants, rvalid, rdata, memory command)
// master: client/memory view (the opposite directions)
interface mem_arbiter_if #(parameter int width = 4, parameter int data_width = 8);
  logic req0, req1, we0, we1;
  logic [width-1:0] addr0, addr1;
  logic [data_width-1:0] wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1;
  logic [data_width-1:0] rdata;
  logic mem_write_enb, mem_read_enb;
  logic [width-1:0] mem_address;
  logic [data_width-1:0] mem_data_in, mem_data_out;
  modport slave (
    input req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_write_enb, mem_read_enb, mem_address, mem_data_in
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input gnt0, gnt1, rvalid0, rvalid1, rdata, mem_write_enb, mem_read_enb, mem_address, mem_data_in
  );
endinterface

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: combinational 2-way round-robin pick
// req: pending requests; last_gnt: previous winner; winner: chosen index; valid: any request pending
module mem_arb_rr import mem_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           last_gnt,
  output req_idx_t           winner,
  output logic               valid
);
  assign valid = |req;
  // on a tie the requester that did not win last time goes next
  assign winner = &req ? ~last_gnt : req_idx_t'(req[1]);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and sequencer for two clients in front of a single-port memory
// clk/reset: clock and synchronous active-high reset
// bus.slave: client req/we/addr/wdata in, gnt/rvalid/rdata out; memory write/read enable, address, data_in out, data_out in
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int width = 4,
  parameter int data_width = 8
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  state_t state_q, state_d;
  req_idx_t last_q, last_d, owner_q, owner_d, winner;
  logic valid, take, win_we;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic wen_q, wen_d, ren_q, ren_d;
  logic [width-1:0] addr_q, addr_d;
  logic [data_width-1:0] wdata_q, wdata_d;
  mem_arb_rr u_rr (
    .req({bus.req1, bus.req0}),
    .last_gnt(last_q),
    .winner(winner),
    .valid(valid)
  );
  assign win_we = winner ? bus.we1 : bus.we0;
  // requests are only looked at in IDLE; outputs are computed one cycle ahead so they come straight from flops
  always_comb begin
    take = state_q == IDLE && valid;
    state_d = take ? ACCESS : (state_q == ACCESS && ren_q) ? RESP : IDLE;
    last_d = take ? winner : last_q;
    owner_d = take ? winner : owner_q;
    gnt_d = take ? (winner ? 2'b10 : 2'b01) : 2'b00;
    wen_d = take && win_we;
    ren_d = take && !win_we;
    addr_d = take ? (winner ? bus.addr1 : bus.addr0) : addr_q;
    wdata_d = take ? (winner ? bus.wdata1 : bus.wdata0) : wdata_q;
    rvalid_d = (state_q == ACCESS && ren_q) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= req_idx_t'(1);
      owner_q <= '0;
      gnt_q <= '0;
      rvalid_q <= '0;
      wen_q <= 1'b0;
      ren_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      owner_q <= owner_d;
      gnt_q <= gnt_d;
      rvalid_q <= rvalid_d;
      wen_q <= wen_d;
      ren_q <= ren_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign bus.gnt0 = gnt_q[0];
  assign bus.gnt1 = gnt_q[1];
  assign bus.rvalid0 = rvalid_q[0];
  assign bus.rvalid1 = rvalid_q[1];
  assign bus.mem_write_enb = wen_q;
  assign bus.mem_read_enb = ren_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data_in = wdata_q;
  assign bus.rdata = bus.mem_data_out;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random check of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mem_arbiter_if bus ();
  mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  logic [7:0] mem [16] = '{default: 8'h00};
  always @(posedge clk) begin
    if (bus.mem_write_enb) mem[bus.mem_address] <= bus.mem_data_in;
    if (bus.mem_read_enb) bus.mem_data_out <= mem[bus.mem_address];
  end
  logic [7:0] ref_mem [16] = '{default: 8'h00};
  logic pv [2];
  logic pwe [2];
  logic [3:0] pa [2];
  logic [7:0] pd [2];
  int last;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive();
    bus.req0 = pv[0]; bus.we0 = pwe[0]; bus.addr0 = pa[0]; bus.wdata0 = pd[0];
    bus.req1 = pv[1]; bus.we1 = pwe[1]; bus.addr1 = pa[1]; bus.wdata1 = pd[1];
  endtask
  task automatic set_cmd(input int i, input logic we, input logic [3:0] a, input logic [7:0] d);
    pv[i] = 1'b1; pwe[i] = we; pa[i] = a; pd[i] = d;
  endtask
  task automatic rand_cmd(input int i);
    set_cmd(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
  endtask
  task automatic idle_chk(input string tag);
    chk(tag, {bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, bus.mem_write_enb, bus.mem_read_enb}, 0);
  endtask
  // one transaction starting from an IDLE cycle with something pending; ends in the following IDLE cycle
  // mode: 0 winner drops its request, 1 winner keeps the same command, 2 winner issues a new random command
  task automatic txn(input int mode, input bit late);
    int w;
    logic we;
    logic [3:0] a;
    logic [7:0] d;
    w = (pv[0] && pv[1]) ? 1 - last : (pv[1] ? 1 : 0);
    we = pwe[w]; a = pa[w]; d = pd[w];
    step();
    last = w;
    chk("gnt", {bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0}, w ? 4'b1000 : 4'b0100);
    chk("enb", {bus.mem_write_enb, bus.mem_read_enb}, we ? 2'b10 : 2'b01);
    chk("maddr", bus.mem_address, a);
    if (we) begin
      chk("mdata", bus.mem_data_in, d);
      ref_mem[a] = d;
    end
    if (mode == 0) pv[w] = 1'b0;
    else if (mode == 2) rand_cmd(w);
    if (late && !pv[1-w]) rand_cmd(1 - w);
    drive();
    step();
    if (!we) begin
      chk("resp", {bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, bus.mem_write_enb, bus.mem_read_enb},
          w ? 6'b001000 : 6'b000100);
      chk("rdata", bus.rdata, ref_mem[a]);
      step();
    end
    idle_chk("idle");
  endtask
  initial begin
    for (int i = 0; i < 2; i++) set_cmd(i, 1'b0, 4'h0, 8'h00);
    pv[1] = 1'b0;
    set_cmd(0, 1'b1, 4'd7, 8'h3C);
    drive();
    step();
    idle_chk("rst1");
    step();
    idle_chk("rst2");
    reset = 1'b0;
    last = 1;
    pv[0] = 1'b0;
    drive();
    step();
    idle_chk("post_rst_idle");
    set_cmd(0, 1'b1, 4'd1, 8'h11);
    set_cmd(1, 1'b1, 4'd2, 8'h22);
    drive();
    for (int k = 0; k < 8; k++) txn(1, 1'b0);
    pv[0] = 1'b0; pv[1] = 1'b0;
    drive();
    step();
    idle_chk("quiet");
    set_cmd(0, 1'b0, 4'd1, 8'h00);
    set_cmd(1, 1'b0, 4'd2, 8'h00);
    drive();
    txn(0, 1'b0);
    txn(0, 1'b0);
    set_cmd(0, 1'b1, 4'd3, 8'hA5);
    drive();
    txn(0, 1'b0);
    set_cmd(0, 1'b0, 4'd3, 8'h00);
    drive();
    txn(0, 1'b0);
    set_cmd(0, 1'b0, 4'd2, 8'h00);
    drive();
    txn(0, 1'b1);
    txn(0, 1'b0);
    set_cmd(0, 1'b0, 4'd5, 8'h00);
    drive();
    step();
    chk("mid_gnt", {bus.gnt1, bus.gnt0, bus.mem_read_enb}, 3'b011);
    reset = 1'b1;
    pv[0] = 1'b0;
    drive();
    step();
    idle_chk("mid_rst");
    reset = 1'b0;
    last = 1;
    step();
    idle_chk("mid_rst_idle");
    set_cmd(1, 1'b0, 4'd2, 8'h00);
    drive();
    txn(0, 1'b0);
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 2; i++) if (!pv[i] && $urandom_range(0, 2) == 0) rand_cmd(i);
      drive();
      if (pv[0] || pv[1]) txn(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      else begin
        step();
        idle_chk("rnd_idle");
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
